// File: rtl/snowv_gcm_pkg.sv
// snowv_gcm_pkg: shared state encodings, command codes and widths for the snowv_gcm sequencer
package snowv_gcm_pkg;
   localparam int BLK_W = 128;
   localparam int KEY_W = 256;
   localparam logic [2:0] CMD_NONE    = 3'd0;
   localparam logic [2:0] CMD_INIT    = 3'd1;
   localparam logic [2:0] CMD_NEXT_AD = 3'd2;
   localparam logic [2:0] CMD_NEXT    = 3'd3;
   localparam logic [2:0] CMD_FINAL   = 3'd4;
   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_W_INIT, S_AD_IN, S_AD_CMD, S_W_AD, S_MSG_IN,
      S_MSG_CMD, S_W_MSG, S_MSG_OUT, S_FINAL, S_W_TAG, S_TAG_OUT
   } seq_state_e;
   typedef enum logic [1:0] {I_IDLE, I_PULSE, I_SETTLE, I_WAIT} iss_state_e;
   typedef struct packed {
      logic             encdec;
      logic [KEY_W-1:0] key;
      logic [BLK_W-1:0] iv;
      logic [63:0]      len_ad;
      logic [63:0]      len_msg;
   } cfg_t;
endpackage

// File: rtl/snowv_gcm_cmd_issue.sv
// snowv_gcm_cmd_issue: tracks one core command through pulse, settle and wait-for-ready
module snowv_gcm_cmd_issue
   import snowv_gcm_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic req,
   input  logic sel_tag,
   input  logic core_ready,
   input  logic core_tag_ready,
   output logic done
);
   iss_state_e st_q, st_d;
   // ready is stale during the pulse and settle cycles, so only WAIT may observe it
   assign done = (st_q == I_WAIT) && (sel_tag ? core_tag_ready : core_ready);
   always_comb begin
      st_d = (st_q == I_IDLE)   ? (req ? I_PULSE : I_IDLE) :
             (st_q == I_PULSE)  ? I_SETTLE :
             (st_q == I_SETTLE) ? I_WAIT :
             (done ? I_IDLE : I_WAIT);
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) st_q <= I_IDLE;
      else         st_q <= st_d;
   end
endmodule

// File: rtl/snowv_gcm_seq.sv
// snowv_gcm_seq: autonomous job sequencer driving the snowv_gcm AEAD core
module snowv_gcm_seq
   import snowv_gcm_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               encdec,
   input  logic [KEY_W-1:0]   key,
   input  logic [BLK_W-1:0]   iv,
   input  logic [CNT_W-1:0]   n_ad,
   input  logic [CNT_W-1:0]   n_msg,
   input  logic [63:0]        len_ad,
   input  logic [63:0]        len_msg,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLK_W-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLK_W-1:0]   out_data,
   output logic               tag_valid,
   input  logic               tag_ready_i,
   output logic [BLK_W-1:0]   tag,
   output logic               busy,
   output logic               core_init,
   output logic               core_next_ad,
   output logic               core_next,
   output logic               core_finalize,
   output logic               core_encdec,
   output logic [KEY_W-1:0]   core_key,
   output logic [BLK_W-1:0]   core_iv,
   output logic [BLK_W-1:0]   core_ad,
   output logic [BLK_W-1:0]   core_block_i,
   output logic [63:0]        core_len_ad,
   output logic [63:0]        core_len_i,
   input  logic [BLK_W-1:0]   core_block_o,
   input  logic [BLK_W-1:0]   core_tag,
   input  logic               core_ready,
   input  logic               core_tag_ready
);
   seq_state_e state_q, state_d;
   cfg_t cfg_q, cfg_d;
   logic [CNT_W-1:0] n_ad_q, n_ad_d, n_msg_q, n_msg_d, ad_cnt_q, ad_cnt_d, msg_cnt_q, msg_cnt_d;
   logic [BLK_W-1:0] ad_q, ad_d, blk_q, blk_d, out_q, out_d, tag_q, tag_d;
   logic [2:0] cmd_q, cmd_d;
   logic done;
   snowv_gcm_cmd_issue u_issue (
      .clk            (clk),
      .resetn         (resetn),
      .req            (cmd_d != CMD_NONE),
      .sel_tag        (state_q == S_W_TAG),
      .core_ready     (core_ready),
      .core_tag_ready (core_tag_ready),
      .done           (done)
   );
   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      n_ad_d    = n_ad_q;
      n_msg_d   = n_msg_q;
      ad_cnt_d  = ad_cnt_q;
      msg_cnt_d = msg_cnt_q;
      ad_d      = ad_q;
      blk_d     = blk_q;
      out_d     = out_q;
      tag_d     = tag_q;
      cmd_d     = CMD_NONE;
      case (state_q)
         S_IDLE: if (start) begin
            cfg_d     = '{encdec: encdec, key: key, iv: iv, len_ad: len_ad, len_msg: len_msg};
            n_ad_d    = n_ad;
            n_msg_d   = n_msg;
            ad_cnt_d  = '0;
            msg_cnt_d = '0;
            state_d   = S_INIT;
         end
         S_INIT: begin
            cmd_d   = CMD_INIT;
            state_d = S_W_INIT;
         end
         // counters are zero after init, so one decision covers both wait states
         S_W_INIT, S_W_AD: if (done)
            state_d = (ad_cnt_q != n_ad_q) ? S_AD_IN : (msg_cnt_q != n_msg_q) ? S_MSG_IN : S_FINAL;
         S_AD_IN: if (in_valid) begin
            ad_d     = in_data;
            ad_cnt_d = ad_cnt_q + CNT_W'(1);
            state_d  = S_AD_CMD;
         end
         S_AD_CMD: begin
            cmd_d   = CMD_NEXT_AD;
            state_d = S_W_AD;
         end
         S_MSG_IN: if (in_valid) begin
            blk_d     = in_data;
            msg_cnt_d = msg_cnt_q + CNT_W'(1);
            state_d   = S_MSG_CMD;
         end
         S_MSG_CMD: begin
            cmd_d   = CMD_NEXT;
            state_d = S_W_MSG;
         end
         S_W_MSG: if (done) begin
            out_d   = core_block_o;
            state_d = S_MSG_OUT;
         end
         S_MSG_OUT: if (out_ready) state_d = (msg_cnt_q != n_msg_q) ? S_MSG_IN : S_FINAL;
         S_FINAL: begin
            cmd_d   = CMD_FINAL;
            state_d = S_W_TAG;
         end
         S_W_TAG: if (done) begin
            tag_d   = core_tag;
            state_d = S_TAG_OUT;
         end
         S_TAG_OUT: if (tag_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cfg_q     <= '0;
         n_ad_q    <= '0;
         n_msg_q   <= '0;
         ad_cnt_q  <= '0;
         msg_cnt_q <= '0;
         ad_q      <= '0;
         blk_q     <= '0;
         out_q     <= '0;
         tag_q     <= '0;
         cmd_q     <= CMD_NONE;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         n_ad_q    <= n_ad_d;
         n_msg_q   <= n_msg_d;
         ad_cnt_q  <= ad_cnt_d;
         msg_cnt_q <= msg_cnt_d;
         ad_q      <= ad_d;
         blk_q     <= blk_d;
         out_q     <= out_d;
         tag_q     <= tag_d;
         cmd_q     <= cmd_d;
      end
   end
   assign in_ready      = (state_q == S_AD_IN) || (state_q == S_MSG_IN);
   assign out_valid     = state_q == S_MSG_OUT;
   assign tag_valid     = state_q == S_TAG_OUT;
   assign busy          = state_q != S_IDLE;
   assign out_data      = out_q;
   assign tag           = tag_q;
   assign core_init     = cmd_q == CMD_INIT;
   assign core_next_ad  = cmd_q == CMD_NEXT_AD;
   assign core_next     = cmd_q == CMD_NEXT;
   assign core_finalize = cmd_q == CMD_FINAL;
   assign core_encdec   = cfg_q.encdec;
   assign core_key      = cfg_q.key;
   assign core_iv       = cfg_q.iv;
   assign core_len_ad   = cfg_q.len_ad;
   assign core_len_i    = cfg_q.len_msg;
   assign core_ad       = ad_q;
   assign core_block_i  = blk_q;
endmodule

// File: tb/tb_snowv_gcm_seq.sv
// tb_snowv_gcm_seq: directed bench for snowv_gcm_seq against a behavioural core stub
module tb_snowv_gcm_seq;
   logic clk = 0, resetn = 0, start = 0, encdec = 0;
   logic [255:0] key = '0;
   logic [127:0] iv = '0, in_data = '0;
   logic [15:0] n_ad = '0, n_msg = '0;
   logic [63:0] len_ad = '0, len_msg = '0;
   logic in_valid = 0, out_ready = 0, tag_ready_i = 0;
   logic in_ready, out_valid, tag_valid, busy;
   logic [127:0] out_data, tag;
   logic core_init, core_next_ad, core_next, core_finalize, core_encdec;
   logic [255:0] core_key;
   logic [127:0] core_iv, core_ad, core_block_i, core_block_o, core_tag;
   logic [63:0] core_len_ad, core_len_i;
   logic core_ready, core_tag_ready;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   snowv_gcm_seq #(.CNT_W(16)) dut (
      .clk(clk), .resetn(resetn), .start(start), .encdec(encdec), .key(key), .iv(iv),
      .n_ad(n_ad), .n_msg(n_msg), .len_ad(len_ad), .len_msg(len_msg),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .tag_valid(tag_valid), .tag_ready_i(tag_ready_i), .tag(tag), .busy(busy),
      .core_init(core_init), .core_next_ad(core_next_ad), .core_next(core_next),
      .core_finalize(core_finalize), .core_encdec(core_encdec), .core_key(core_key),
      .core_iv(core_iv), .core_ad(core_ad), .core_block_i(core_block_i),
      .core_len_ad(core_len_ad), .core_len_i(core_len_i), .core_block_o(core_block_o),
      .core_tag(core_tag), .core_ready(core_ready), .core_tag_ready(core_tag_ready)
   );

   function automatic logic [127:0] rotl(input logic [127:0] a);
      return {a[126:0], a[127]};
   endfunction

   // core stub: ready stays stale-high through pulse and settle, then drops for 4 cycles
   int c_cnt = 0, c_idx = 0, n_init = 0, n_nad = 0, n_next = 0, n_fin = 0, n_pulse = 0;
   logic [127:0] c_acc = '0, c_bo = '0, c_tag = '0, p_bo = '0, p_tag = '0;
   logic c_trdy = 0, p_fin = 0;
   logic [63:0] plog = '0;
   assign core_ready = (c_cnt == 0) || (c_cnt == 5);
   assign core_tag_ready = c_trdy && (c_cnt == 0);
   assign core_block_o = c_bo;
   assign core_tag = c_tag;
   always @(posedge clk) begin
      if (c_cnt > 0) c_cnt <= c_cnt - 1;
      if (c_cnt == 1) begin
         c_bo <= p_bo;
         if (p_fin) begin c_tag <= p_tag; c_trdy <= 1; end
      end
      if (core_init || core_next_ad || core_next || core_finalize) begin
         c_cnt <= 5;
         n_pulse <= n_pulse + 1;
      end
      if (core_init) begin
         c_acc <= core_iv ^ core_key[127:0]; c_idx <= 0; c_trdy <= 0; p_fin <= 0;
         n_init <= n_init + 1; plog <= {plog[59:0], 4'h1};
      end
      if (core_next_ad) begin
         c_acc <= rotl(c_acc) ^ core_ad;
         n_nad <= n_nad + 1; plog <= {plog[59:0], 4'h2};
      end
      if (core_next) begin
         p_bo  <= core_block_i ^ (core_key[255:128] + 128'(c_idx));
         c_acc <= rotl(c_acc) ^ (core_encdec ? core_block_i ^ (core_key[255:128] + 128'(c_idx)) : core_block_i);
         c_idx <= c_idx + 1;
         n_next <= n_next + 1; plog <= {plog[59:0], 4'h3};
      end
      if (core_finalize) begin
         p_tag <= c_acc ^ {core_len_ad, core_len_i}; p_fin <= 1;
         n_fin <= n_fin + 1; plog <= {plog[59:0], 4'h4};
      end
   end

   task automatic check(input string t, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", t, got, exp);
      end
   endtask

   logic [255:0] job_key;
   logic [127:0] job_iv, ref_t, tag_r, enc_tag;
   logic [63:0] job_lad, job_lmsg;
   logic [127:0] ad_v[4], msg_v[4], out_v[4], ref_o[4], pt[4], ct[4];
   int inr_cyc;

   task automatic ref_model(input bit enc, input int na, input int nm);
      logic [127:0] acc;
      acc = job_iv ^ job_key[127:0];
      for (int i = 0; i < na; i++) acc = rotl(acc) ^ ad_v[i];
      for (int i = 0; i < nm; i++) begin
         ref_o[i] = msg_v[i] ^ (job_key[255:128] + 128'(i));
         acc = rotl(acc) ^ (enc ? ref_o[i] : msg_v[i]);
      end
      ref_t = acc ^ {job_lad, job_lmsg};
   endtask

   task automatic run_job(input bit enc, input int na, input int nm, input int stall_blk, input bit poke);
      int ai, mi, oi, stall, nx0;
      bit done, poked, stable_ok;
      logic [127:0] held;
      logic [63:0] el, mask;
      ai = 0; mi = 0; oi = 0; nx0 = 0; done = 0; poked = 0; stable_ok = 1; held = '0; inr_cyc = 0;
      stall = (stall_blk >= 0) ? 10 : 0;
      @(negedge clk);
      encdec = enc; key = job_key; iv = job_iv; n_ad = 16'(na); n_msg = 16'(nm);
      len_ad = job_lad; len_msg = job_lmsg; start = 1;
      @(negedge clk);
      start = 0;
      for (int c = 0; c < 3000 && !done; c++) begin
         encdec = enc; key = job_key; iv = job_iv; n_ad = 16'(na); n_msg = 16'(nm); start = 0;
         if (poke && !poked && core_next) begin
            start = 1; encdec = !enc; key = ~job_key; iv = ~job_iv; n_ad = 0; n_msg = 0; poked = 1;
         end
         if (in_ready) inr_cyc++;
         in_valid = (ai < na) || (mi < nm);
         in_data = (ai < na) ? ad_v[ai] : msg_v[mi & 3];
         if (in_ready && in_valid) begin
            if (ai < na) ai++; else mi++;
         end
         out_ready = 1;
         if (oi == stall_blk && stall > 0 && stall < 10 && !out_valid) stable_ok = 0;
         if (out_valid && oi == stall_blk && stall > 0) begin
            out_ready = 0;
            if (stall == 10) begin held = out_data; nx0 = n_next; end
            else if (out_data !== held) stable_ok = 0;
            if (core_next) stable_ok = 0;
            stall--;
         end else if (out_valid) begin
            if (oi == stall_blk) begin
               check("stall_hold", {255'd0, stable_ok && out_data === held}, 256'd1);
               check("stall_no_next", n_next - nx0, 0);
            end
            out_v[oi & 3] = out_data;
            oi++;
         end
         tag_ready_i = tag_valid;
         if (tag_valid) begin
            tag_r = tag;
            done = 1;
            check("busy_at_tag", busy, 1);
         end
         @(negedge clk);
      end
      tag_ready_i = 0; in_valid = 0; start = 0;
      if (!done) check("timeout", 0, 1);
      check("busy_fall", busy, 0);
      check("n_out", oi, nm);
      el = '0;
      el = {el[59:0], 4'h1};
      for (int i = 0; i < na; i++) el = {el[59:0], 4'h2};
      for (int i = 0; i < nm; i++) el = {el[59:0], 4'h3};
      el = {el[59:0], 4'h4};
      mask = (64'h1 << (4 * (na + nm + 2))) - 64'h1;
      check("pulse_order", plog & mask, el);
   endtask

   initial begin
      int p0, i0, f0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_tag_valid", tag_valid, 0);
      check("rst_pulses", {core_init, core_next_ad, core_next, core_finalize}, 0);
      check("rst_key", core_key, 0);
      check("rst_out", out_data, 0);
      check("rst_tag", tag, 0);
      resetn = 1;
      // job 0: empty AD and payload
      job_key = '0; job_iv = '0; job_lad = '0; job_lmsg = '0;
      i0 = n_init; f0 = n_fin;
      ref_model(1, 0, 0);
      run_job(1, 0, 0, -1, 0);
      check("j0_in_ready_cycles", inr_cyc, 0);
      check("j0_inits", n_init - i0, 1);
      check("j0_finals", n_fin - f0, 1);
      check("j0_tag", tag_r, ref_t);
      // job 1: 2 AD, 3 payload, encrypt
      job_key = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;
      job_iv = 128'hcafebabedeadbeef0011223344556677;
      job_lad = 64'd256; job_lmsg = 64'd384;
      ad_v[0] = 128'h11111111222222223333333344444444;
      ad_v[1] = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;
      msg_v[0] = 128'h000102030405060708090a0b0c0d0e0f;
      msg_v[1] = 128'h101112131415161718191a1b1c1d1e1f;
      msg_v[2] = 128'hffeeddccbbaa99887766554433221100;
      for (int i = 0; i < 3; i++) pt[i] = msg_v[i];
      ref_model(1, 2, 3);
      run_job(1, 2, 3, -1, 0);
      for (int i = 0; i < 3; i++) check($sformatf("j1_out%0d", i), out_v[i], ref_o[i]);
      check("j1_tag", tag_r, ref_t);
      for (int i = 0; i < 3; i++) ct[i] = ref_o[i];
      enc_tag = ref_t;
      // job 2: stall on the second output block
      run_job(1, 2, 3, 1, 0);
      for (int i = 0; i < 3; i++) check($sformatf("j2_out%0d", i), out_v[i], ct[i]);
      check("j2_tag", tag_r, enc_tag);
      // job 3: decrypt the job-1 ciphertext
      for (int i = 0; i < 3; i++) msg_v[i] = ct[i];
      run_job(0, 2, 3, -1, 0);
      for (int i = 0; i < 3; i++) check($sformatf("j3_out%0d", i), out_v[i], pt[i]);
      check("j3_tag", tag_r, enc_tag);
      for (int i = 0; i < 3; i++) msg_v[i] = pt[i];
      // job 4: start pulsed with junk config while busy
      run_job(1, 2, 3, -1, 1);
      for (int i = 0; i < 3; i++) check($sformatf("j4_out%0d", i), out_v[i], ct[i]);
      check("j4_tag", tag_r, enc_tag);
      check("j4_key", core_key, job_key);
      check("j4_iv", core_iv, job_iv);
      check("j4_encdec", core_encdec, 1);
      // abort with reset while waiting on next_ad
      @(negedge clk);
      encdec = 1; key = job_key; iv = job_iv; n_ad = 2; n_msg = 3; start = 1;
      @(negedge clk);
      start = 0;
      for (int c = 0; c < 200 && !core_next_ad; c++) begin
         in_valid = 1; in_data = ad_v[0];
         @(negedge clk);
      end
      check("abort_reach", core_next_ad, 1);
      in_valid = 0;
      @(negedge clk);
      resetn = 0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_ad", core_ad, 0);
      check("abort_key", core_key, 0);
      check("abort_pulses", {core_init, core_next_ad, core_next, core_finalize}, 0);
      check("abort_valids", {in_ready, out_valid, tag_valid}, 0);
      p0 = n_pulse;
      repeat (4) @(negedge clk);
      check("abort_no_pulse", n_pulse - p0, 0);
      resetn = 1;
      run_job(1, 2, 3, -1, 0);
      for (int i = 0; i < 3; i++) check($sformatf("j5_out%0d", i), out_v[i], ct[i]);
      check("j5_tag", tag_r, enc_tag);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/snowv_gcm_seq.md
Name: snowv_gcm_seq

Overview:
- Autonomous sequencer for the snowv_gcm AEAD core.
- Takes one job configuration (key, IV, mode, block counts, bit lengths), then streams AD and payload blocks through valid/ready interfaces.
- Issues init / next_ad / next / finalize pulses in the correct order and returns output blocks and the tag.
- Replaces per-command software sequencing over the ARM command wrapper.

Parameters:
CNT_W, 16, width of the AD and payload block counters (max 2^CNT_W-1 blocks each)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle job start; sampled only in IDLE
encdec  in  1  1=encrypt, 0=decrypt; latched at start
key  in  256  key; latched at start
iv  in  128  IV; latched at start
n_ad  in  CNT_W  number of AD blocks; latched at start
n_msg  in  CNT_W  number of payload blocks; latched at start
len_ad  in  64  total AD length in bits; latched at start
len_msg  in  64  total payload length in bits; latched at start
in_valid  in  1  input block valid
in_ready  out  1  input block accepted when in_valid&in_ready
in_data  in  128  AD or payload block, zero-padded by upstream
out_valid  out  1  output block valid
out_ready  in  1  downstream accepts output block
out_data  out  128  encrypted/decrypted block
tag_valid  out  1  tag valid; held until tag_ready_i
tag_ready_i  in  1  downstream accepts tag
tag  out  128  authentication tag
busy  out  1  high in every state except IDLE
core_init, core_next_ad, core_next, core_finalize  out  1 each  single-cycle core command pulses
core_encdec  out  1  latched encdec
core_key  out  256  latched key
core_iv  out  128  latched IV
core_ad  out  128  registered AD block
core_block_i  out  128  registered payload block
core_len_ad  out  64  latched len_ad
core_len_i  out  64  latched len_msg
core_block_o  in  128  core output block
core_tag  in  128  core tag
core_ready  in  1  core idle/result ready
core_tag_ready  in  1  core tag ready

Behaviour:
- Reset: all outputs and registers 0; state IDLE.
- Asserting resetn low mid-job aborts it: no pulses after reset; counters cleared.
- Core commands: every command pulse is followed by one settle cycle in which core_ready/core_tag_ready are ignored. The sequencer then waits for core_ready high (core_tag_ready after finalize).
- States:
  - IDLE: on start, latch config, clear ad_cnt/msg_cnt -> INIT.
  - INIT: pulse core_init -> W_INIT.
  - W_INIT: after settle and core_ready -> AD_IN if n_ad!=0; else MSG_IN if n_msg!=0; else FINAL.
  - AD_IN: in_ready=1; on accept, register core_ad<=in_data, ad_cnt++ -> AD_CMD.
  - AD_CMD: pulse core_next_ad -> W_AD.
  - W_AD: after settle and core_ready -> AD_IN if ad_cnt!=n_ad; else MSG_IN if n_msg!=0; else FINAL.
  - MSG_IN: in_ready=1; on accept, core_block_i<=in_data, msg_cnt++ -> MSG_CMD.
  - MSG_CMD: pulse core_next -> W_MSG.
  - W_MSG: after settle and core_ready, register out_data<=core_block_o, out_valid=1 -> MSG_OUT.
  - MSG_OUT: hold out_valid/out_data until out_ready. On handshake -> MSG_IN if msg_cnt!=n_msg, else FINAL.
  - FINAL: pulse core_finalize -> W_TAG.
  - W_TAG: after settle and core_tag_ready, tag<=core_tag, tag_valid=1 -> TAG_OUT.
  - TAG_OUT: hold until tag_ready_i; on handshake tag_valid=0 -> IDLE.
- in_ready is registered-state-decoded and is never high outside AD_IN/MSG_IN. Only one block is in flight at a time (no pipelining).
- start outside IDLE is ignored. out_valid must not drop before out_ready.
- Counters compare by equality; n_ad or n_msg = 0 skips that phase. Counter wrap is impossible because each counter increments at most up to its latched target.
- Minimum latency of a 0/0 job from start to tag_valid: 1 (latch) + 1 (init) + settle + core time + 1 (finalize) + settle + core time.

Decomposition:
- Package snowv_gcm_pkg: state encoding localparams, CMD_* constants shared with the ARM wrapper, block width 128, key width 256.
- Sub-module snowv_gcm_cmd_issue: pulse + settle + wait-ready handshake with the core. Inputs: cmd request, which ready to watch. Output: done. Instantiated once and reused by all command states.

Test Plan:
- n_ad=0, n_msg=0, len_ad=len_msg=0, key=0, iv=0 -> exactly one init and one finalize pulse, zero in_ready cycles, tag_valid with the core tag, busy falls the cycle after the tag handshake.
- n_ad=2, n_msg=3, encrypt, reference key/IV -> pulse order init, next_ad x2, next x3, finalize; 3 out blocks and the tag match the C model.
- Same job with out_ready held low 10 cycles on block 2 -> out_data stable, no further core_next until the handshake, final tag unchanged.
- Decrypt the ciphertext produced by the n_ad=2, n_msg=3 job -> out_data equals the original plaintext and the tag equals the encrypt tag.
- start pulsed while busy (in W_MSG) -> ignored; latched config unchanged, result identical.
- resetn asserted during W_AD -> all outputs 0, state IDLE; a following fresh job completes correctly.
